// File: rtl/binary_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : binary_frame_writer
//  Description : Thresholds streaming 8-bit luminance into a 1-bit frame buffer
//                (1 = white) and hands each complete frame to the finder.
//                Optional hysteresis band: BINARY_FRAME_WRITER_HYST_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_frame_writer #(
    parameter int         WIDTH     = 640,
    parameter int         HEIGHT    = 480,
    parameter logic [7:0] THRESHOLD = 8'd128,
    parameter logic [7:0] HYST      = 8'd8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid_in,
    input  logic        frame_start_in,
    input  logic        finder_done_in,
    output logic [19:0] write_address,
    output logic        write_data,
    output logic        write_enable,
    output logic        start_finder,
    output logic        frame_busy
);

`ifdef BINARY_FRAME_WRITER_HYST_EN
    localparam bit c_hyst_en = 1'b1;
`else
    localparam bit c_hyst_en = 1'b0;
`endif

    localparam logic [9:0]        c_x_last = 10'(WIDTH - 1);
    localparam logic [8:0]        c_y_last = 9'(HEIGHT - 1);
    localparam logic signed [9:0] c_hyst   = $signed({2'b00, HYST});

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        CAPTURE    = 2'd1,
        HANDOFF    = 2'd2,
        HOLD       = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic [9:0]  r_x, w_x_next;
    logic [8:0]  r_y, w_y_next;
    logic [19:0] r_addr, w_addr_next;   // address the next accepted pixel lands on
    logic [19:0] w_wr_addr_next;
    logic        w_wr_data_next, w_wr_en_next, w_start_next, w_busy_next;

    logic signed [9:0] w_diff;
    logic              w_in_band, w_row_start, w_plain_bit, w_bit, w_accept_start;

    // One guard bit beyond 9 keeps the signed difference free of wraparound
    // for any THRESHOLD value.
    assign w_diff         = $signed({2'b00, pixel_in}) - $signed({2'b00, THRESHOLD});
    assign w_in_band      = (w_diff <= c_hyst) && (w_diff >= -c_hyst);
    assign w_row_start    = frame_start_in || (r_x == 10'd0);
    assign w_plain_bit    = (pixel_in >= THRESHOLD);
    assign w_bit          = (c_hyst_en && w_in_band && !w_row_start) ? write_data : w_plain_bit;
    assign w_accept_start = pixel_valid_in && frame_start_in;

    always_comb begin
        w_state_next   = r_state;
        w_x_next       = r_x;
        w_y_next       = r_y;
        w_addr_next    = r_addr;
        w_wr_addr_next = write_address;
        w_wr_data_next = write_data;
        w_wr_en_next   = 1'b0;
        w_start_next   = 1'b0;
        w_busy_next    = frame_busy;

        case (r_state)
            WAIT_FRAME, CAPTURE: begin
                if (w_accept_start) begin
                    w_wr_en_next   = 1'b1;
                    w_wr_addr_next = 20'd0;
                    w_wr_data_next = w_bit;
                    w_x_next       = 10'd1;
                    w_y_next       = 9'd0;
                    w_addr_next    = 20'd1;
                    w_state_next   = CAPTURE;
                end else if ((r_state == CAPTURE) && pixel_valid_in) begin
                    w_wr_en_next   = 1'b1;
                    w_wr_addr_next = r_addr;
                    w_wr_data_next = w_bit;
                    w_addr_next    = r_addr + 20'd1;
                    w_x_next       = r_x + 10'd1;
                    if (r_x == c_x_last) begin
                        w_x_next = 10'd0;
                        w_y_next = r_y + 9'd1;
                        if (r_y == c_y_last) begin
                            w_y_next     = 9'd0;
                            w_addr_next  = 20'd0;
                            w_state_next = HANDOFF;
                        end
                    end
                end
            end
            HANDOFF: begin
                w_start_next = 1'b1;
                w_busy_next  = 1'b1;
                w_state_next = HOLD;
            end
            HOLD: begin
                if (finder_done_in) begin
                    w_busy_next  = 1'b0;
                    w_state_next = WAIT_FRAME;
                end
            end
            default: w_state_next = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= WAIT_FRAME;
            r_x           <= 10'd0;
            r_y           <= 9'd0;
            r_addr        <= 20'd0;
            write_address <= 20'd0;
            write_data    <= 1'b0;
            write_enable  <= 1'b0;
            start_finder  <= 1'b0;
            frame_busy    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_addr        <= w_addr_next;
            write_address <= w_wr_addr_next;
            write_data    <= w_wr_data_next;
            write_enable  <= w_wr_en_next;
            start_finder  <= w_start_next;
            frame_busy    <= w_busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_binary_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_binary_frame_writer
//  Description : Randomized scoreboard bench for binary_frame_writer on a
//                reduced frame geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_frame_writer;

    localparam int         W  = 20;
    localparam int         H  = 5;
    localparam int         TH = 128;
    localparam int         HY = 8;
`ifdef BINARY_FRAME_WRITER_HYST_EN
    localparam bit         HYST_ON = 1'b1;
`else
    localparam bit         HYST_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [7:0]  pixel_in = 8'd0;
    logic        pixel_valid_in = 1'b0;
    logic        frame_start_in = 1'b0;
    logic        finder_done_in = 1'b0;
    logic [19:0] write_address;
    logic        write_data, write_enable, start_finder, frame_busy;

    binary_frame_writer #(
        .WIDTH(W), .HEIGHT(H), .THRESHOLD(8'd128), .HYST(8'd8)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .pixel_in(pixel_in),
        .pixel_valid_in(pixel_valid_in), .frame_start_in(frame_start_in),
        .finder_done_in(finder_done_in), .write_address(write_address),
        .write_data(write_data), .write_enable(write_enable),
        .start_finder(start_finder), .frame_busy(frame_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [19:0] addr; logic data; } wr_t;
    typedef struct packed { logic we; logic sf; logic busy; } ctl_t;

    wr_t  wq[$];
    ctl_t cq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: pixel index within the frame plus a few frame-level flags.
    bit m_cap = 0, m_handoff = 0, m_busy = 0, m_last = 0;
    int m_pos = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit s, input logic [7:0] p, input bit d);
        ctl_t c;
        bit   b;
        int   diff;
        c = '0;
        if (r) begin
            m_cap = 0; m_handoff = 0; m_busy = 0; m_pos = 0;
        end else if (m_handoff) begin
            m_handoff = 0; m_busy = 1; c.sf = 1;
        end else if (m_busy) begin
            if (d) m_busy = 0;
        end else if (v && (s || m_cap)) begin
            if (s) m_pos = 0;
            b    = (int'(p) >= TH);
            diff = int'(p) - TH;
            if (HYST_ON && (m_pos % W) != 0 && diff <= HY && diff >= -HY) b = m_last;
            wq.push_back('{addr: 20'(m_pos), data: b});
            m_last = b;
            c.we   = 1;
            m_cap  = 1;
            m_pos++;
            if (m_pos == W * H) begin
                m_cap = 0; m_pos = 0; m_handoff = 1;
            end
        end
        c.busy = m_busy;
        cq.push_back(c);
    endtask

    task automatic cyc(input bit r, input bit v, input bit s, input logic [7:0] p, input bit d);
        rst_in = r; pixel_valid_in = v; frame_start_in = s; pixel_in = p; finder_done_in = d;
        model_step(r, v, s, p, d);
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] pix_for(input int pos);
        int col, row;
        col = pos % W;
        row = pos / W;
        if (row == 1 && col < 4) begin
            case (col)
                0: return 8'd200;
                1: return 8'd130;
                2: return 8'd125;
                default: return 8'd119;
            endcase
        end
        if (row == 0 && col == W - 1) return 8'd50;
        if (row == 0 && col == 5) return 8'd127;
        if (row == 0 && col == 6) return 8'd128;
        case ($urandom_range(0, 2))
            0: return 8'($urandom_range(0, 255));
            1: return 8'($urandom_range(TH - 12, TH + 12));
            default: return ($urandom_range(0, 1) != 0) ? 8'd127 : 8'd128;
        endcase
    endfunction

    task automatic run_frame(input logic [7:0] first, input int restart_at, input int reset_at,
                             input bit const_pix);
        int guard;
        bit v, s, d, r;
        logic [7:0] p;
        guard = 0;
        cyc(0, 1, 1, first, 0);
        while (m_cap && guard < 2000) begin
            v = const_pix ? 1'b1 : ($urandom_range(0, 3) != 0);
            s = 0;
            r = 0;
            if (v && m_pos == restart_at) begin
                s = 1; restart_at = -1;
            end else if (!v) begin
                s = ($urandom_range(0, 1) != 0);
            end
            d = ($urandom_range(0, 7) == 0);
            if (m_pos == reset_at) begin
                r = 1; reset_at = -1;
            end
            p = const_pix ? 8'd200 : pix_for(s ? 0 : m_pos);
            cyc(r, v, s, p, d);
            guard++;
        end
        if (guard >= 2000) begin
            checks++; errors++;
            $display("FAIL frame_timeout: cycles %0d limit %0d", guard, 2000);
        end
    endtask

    // Monitor: per-cycle control expectations, writes popped on each strobe.
    ctl_t mon_c;
    wr_t  mon_w;
    initial begin
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                mon_c = cq.pop_front();
                chk("write_enable", 32'(write_enable), 32'(mon_c.we));
                chk("start_finder", 32'(start_finder), 32'(mon_c.sf));
                chk("frame_busy",   32'(frame_busy),   32'(mon_c.busy));
            end
            if (write_enable === 1'b1) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0d expected no write", write_address);
                end else begin
                    mon_w = wq.pop_front();
                    chk("write_address", 32'(write_address), 32'(mon_w.addr));
                    chk("write_data",    32'(write_data),    32'(mon_w.data));
                end
            end
        end
    end

    initial begin
        repeat (3) cyc(1, 0, 0, 8'd0, 0);
        chk("reset_address", 32'(write_address), 32'd0);
        chk("reset_data",    32'(write_data),    32'd0);

        // Uniform white frame.
        run_frame(8'd200, -1, -1, 1'b1);
        cyc(0, 1, 0, 8'd0, 1);                    // handoff cycle: done ignored
        repeat (3) cyc(0, 1, 1, 8'd0, 0);          // new frame attempts dropped
        cyc(0, 0, 0, 8'd0, 1);                    // finder releases buffer

        // Immediate restart with a dark pixel, mid-frame restart, then complete.
        run_frame(8'd10, 3 * W + 7, -1, 1'b0);
        repeat (4) cyc(0, 1, 1, 8'd255, 0);
        cyc(0, 0, 0, 8'd0, 1);

        // Frame aborted by reset, then a clean random frame.
        run_frame(8'($urandom_range(0, 255)), -1, 2 * W + 5, 1'b0);
        repeat (2) cyc(0, 0, 0, 8'd0, 0);
        run_frame(8'($urandom_range(0, 255)), -1, -1, 1'b0);
        repeat (2) cyc(0, 0, 0, 8'd0, 0);
        cyc(0, 0, 0, 8'd0, 1);
        repeat (3) cyc(0, 1, 0, 8'd90, 0);

        @(negedge clk);
        #1;
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
